// File: rtl/vga_pixel_pipe.sv
// VGA timing generator and aligned pixel output stage.
// Counters issue fetches; flags are delayed to match framebuffer latency.
module vga_pixel_pipe #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int RD_LAT   = 1,
   parameter int CW       = 5,
   parameter bit SYNC_POL = 1'b0,
   parameter int CNT_W    = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [3*CW:0]   pixel_in,
   output logic [CNT_W-1:0] fetch_x,
   output logic [CNT_W-1:0] fetch_y,
   output logic            fetch_valid,
   output logic            pix_ce,
   output logic [CW-1:0]   red,
   output logic [CW-1:0]   green,
   output logic [CW-1:0]   blue,
   output logic            hSync,
   output logic            vSync,
   output logic            bright,
   output logic            frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic first;
      logic act;
      logic hs;
      logic vs;
   } flags_t;

   logic [DW-1:0]    div;
   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   logic             h_wrap;
   logic             v_wrap;
   flags_t           raw;
   flags_t           d_in;
   flags_t           tail;
   logic             unused_alpha;

   assign unused_alpha = pixel_in[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Gated by reset so the enable is low throughout reset, even at CLK_DIV=1.
   assign pix_ce = reset & (div == DIV_LAST);

   assign h_wrap = (hc == H_LAST);
   assign v_wrap = (vc == V_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hc <= '0;
         vc <= '0;
      end else if (pix_ce) begin
         if (!enable) begin
            hc <= '0;
            vc <= '0;
         end else begin
            hc <= h_wrap ? '0 : hc + 1'b1;
            if (h_wrap) begin
               vc <= v_wrap ? '0 : vc + 1'b1;
            end
         end
      end
   end

   always_comb begin
      raw       = '0;
      raw.act   = (hc < HA) && (vc < VA);
      raw.hs    = (hc >= HS0) && (hc < HS1);
      raw.vs    = (vc >= VS0) && (vc < VS1);
      raw.first = (hc == '0) && (vc == '0);
   end

   // A parked raster feeds blank entries so the pins drain to inactive.
   assign d_in = enable ? raw : '0;

   assign fetch_x     = hc;
   assign fetch_y     = vc;
   assign fetch_valid = raw.act;

   generate
      if (RD_LAT == 0) begin : g_nopipe
         assign tail = d_in;
      end else begin : g_pipe
         flags_t sr [RD_LAT];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < RD_LAT; i++) begin
                  sr[i] <= '0;
               end
            end else if (pix_ce) begin
               sr[0] <= d_in;
               for (int i = 1; i < RD_LAT; i++) begin
                  sr[i] <= sr[i-1];
               end
            end
         end
         assign tail = sr[RD_LAT-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         bright      <= 1'b0;
         hSync       <= ~SYNC_POL;
         vSync       <= ~SYNC_POL;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_ce & tail.first;
         if (pix_ce) begin
            bright <= tail.act;
            red    <= tail.act ? pixel_in[3*CW -: CW] : '0;
            green  <= tail.act ? pixel_in[2*CW -: CW] : '0;
            blue   <= tail.act ? pixel_in[CW -: CW] : '0;
            hSync  <= tail.hs ? SYNC_POL : ~SYNC_POL;
            vSync  <= tail.vs ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Directed bench for vga_pixel_pipe over small, default and corner timings.
// Expected pins come from the raster decode applied to fetch history.
`timescale 1ns/1ps
module tb_vga_pixel_pipe;

   logic clk = 1'b0;
   logic reset;
   logic s_en;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   s_fs_q[$];
   int   v_fs_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [9:0] s_fx, s_fy, d_fx, d_fy, v_fx, v_fy, c_fx, c_fy;
   logic s_fv, d_fv, v_fv, c_fv;
   logic s_ce, d_ce, v_ce, c_ce;
   logic [4:0] s_r, s_g, s_b, d_r, d_g, d_b, v_r, v_g, v_b, c_r, c_g, c_b;
   logic s_hs, s_vs, s_br, s_fs, d_hs, d_vs, d_br, d_fs;
   logic v_hs, v_vs, v_br, v_fs, c_hs, c_vs, c_br, c_fs;
   logic [15:0] s_m0, s_m1, c_pix;

   function automatic logic [15:0] word(input logic [9:0] x, input logic [9:0] y);
      return {x[4:0], y[4:0], x[4:0] ^ 5'h15, 1'b1};
   endfunction

   // Two-tick framebuffer model for the small-timing instance.
   always @(posedge clk) begin
      if (s_ce) begin
         s_m0 <= word(s_fx, s_fy);
         s_m1 <= s_m0;
      end
   end
   assign c_pix = word(c_fx, c_fy);

   vga_pixel_pipe #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(2), .RD_LAT(2), .CW(5), .SYNC_POL(1'b0), .CNT_W(10)
   ) u_s (
      .clk(clk), .reset(reset), .enable(s_en), .pixel_in(s_m1),
      .fetch_x(s_fx), .fetch_y(s_fy), .fetch_valid(s_fv), .pix_ce(s_ce),
      .red(s_r), .green(s_g), .blue(s_b), .hSync(s_hs), .vSync(s_vs),
      .bright(s_br), .frame_start(s_fs)
   );

   vga_pixel_pipe #(.CLK_DIV(2), .RD_LAT(1)) u_d (
      .clk(clk), .reset(reset), .enable(1'b1), .pixel_in(16'hFFFF),
      .fetch_x(d_fx), .fetch_y(d_fy), .fetch_valid(d_fv), .pix_ce(d_ce),
      .red(d_r), .green(d_g), .blue(d_b), .hSync(d_hs), .vSync(d_vs),
      .bright(d_br), .frame_start(d_fs)
   );

   vga_pixel_pipe #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .CLK_DIV(2), .RD_LAT(1)
   ) u_v (
      .clk(clk), .reset(reset), .enable(1'b1), .pixel_in(16'hFFFF),
      .fetch_x(v_fx), .fetch_y(v_fy), .fetch_valid(v_fv), .pix_ce(v_ce),
      .red(v_r), .green(v_g), .blue(v_b), .hSync(v_hs), .vSync(v_vs),
      .bright(v_br), .frame_start(v_fs)
   );

   vga_pixel_pipe #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(1), .RD_LAT(0)
   ) u_c (
      .clk(clk), .reset(reset), .enable(1'b1), .pixel_in(c_pix),
      .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv), .pix_ce(c_ce),
      .red(c_r), .green(c_g), .blue(c_b), .hSync(c_hs), .vSync(c_vs),
      .bright(c_br), .frame_start(c_fs)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int pk(input logic fs, input logic hs, input logic vs,
                             input logic br, input logic [4:0] r,
                             input logic [4:0] g, input logic [4:0] b);
      return int'({13'b0, fs, hs, vs, br, r, g, b});
   endfunction

   // Small-timing decode: active 8x4, hsync x in [10,12), vsync y==5.
   function automatic int exp_px(input int x, input int y, input bit with_fs);
      logic br, hs, vs, fs;
      logic [4:0] r, g, b;
      if (x < 0) return pk(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      br = (x < 8) && (y < 4);
      hs = !(x >= 10 && x < 12);
      vs = !(y == 5);
      fs = with_fs && x == 0 && y == 0;
      r = br ? 5'(x) : 5'd0;
      g = br ? 5'(y) : 5'd0;
      b = br ? (5'(x) ^ 5'h15) : 5'd0;
      return pk(fs, hs, vs, br, r, g, b);
   endfunction

   task automatic tick(input int w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if ((w == 0 && s_ce) || (w == 1 && d_ce) || (w == 2 && v_ce)) return;
      end
      check("tick_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      if (s_fs) begin
         s_fs_q.push_back(cyc);
         check("s_fs_pixel", pk(1'b0, s_hs, s_vs, s_br, s_r, s_g, s_b),
               exp_px(0, 0, 1'b0));
      end
      if (v_fs) v_fs_q.push_back(cyc);
   end

   task automatic run_s();
      int hx[$];
      int hy[$];
      int lc[7];
      foreach (lc[i]) lc[i] = 0;
      repeat (3) begin
         hx.push_back(-1);
         hy.push_back(0);
      end
      for (int k = 0; k < 200; k++) begin
         tick(0);
         hx.push_back(int'(s_fx));
         hy.push_back(int'(s_fy));
         check("s_pins", pk(1'b0, s_hs, s_vs, s_br, s_r, s_g, s_b),
               exp_px(hx[k], hy[k], 1'b0));
         check("s_fvalid", int'(s_fv), int'(s_fx < 8 && s_fy < 4));
         if (k >= 3 && k <= 100 && s_br && hy[k] < 7) lc[hy[k]]++;
      end
      for (int y = 0; y < 7; y++)
         check($sformatf("s_line%0d_bright", y), lc[y], (y < 4) ? 8 : 0);
      check("s_fs_count", int'(s_fs_q.size() >= 2), 1);
      if (s_fs_q.size() >= 2)
         check("s_fs_period", s_fs_q[1] - s_fs_q[0], 196);
   endtask

   task automatic run_d();
      int k0 = -1, kb = -1, kf = -1, kr = -1, nbr = 0, errs = 0;
      for (int k = 0; k < 800; k++) begin
         tick(1);
         if (k0 < 0 && d_fx == 0) k0 = k;
         if (kb < 0 && d_br) kb = k;
         if (kf < 0 && !d_hs) kf = k;
         if (kf >= 0 && kr < 0 && d_hs) kr = k;
         if (d_br) begin
            nbr++;
            if ({d_r, d_g, d_b} != 15'h7FFF) errs++;
         end else if ({d_r, d_g, d_b} != 15'h0) errs++;
      end
      check("d_hs_from_pixel0", kf - kb, 656);
      check("d_hs_from_fetch0", kf - k0, 658);
      check("d_hs_width", kr - kf, 96);
      check("d_line_bright", nbr, 640);
      check("d_blank_mask_errs", errs, 0);
   endtask

   task automatic run_v();
      int kb = -1, kf = -1, kr = -1;
      for (int k = 0; k < 8000 && kr < 0; k++) begin
         tick(2);
         if (kb < 0 && v_br) kb = k;
         if (kf < 0 && !v_vs) kf = k;
         if (kf >= 0 && kr < 0 && v_vs) kr = k;
      end
      check("v_vs_start", kf - kb, 6860);
      check("v_vs_width", kr - kf, 28);
      for (int i = 0; i < 16000 && v_fs_q.size() < 2; i++) @(negedge clk);
      check("v_fs_count", int'(v_fs_q.size() >= 2), 1);
      if (v_fs_q.size() >= 2)
         check("v_fs_period", v_fs_q[1] - v_fs_q[0], 14700);
   endtask

   task automatic run_c();
      int px = 0, py = 0, nx, ny, zero_ce = 0;
      for (int i = 0; i < 220; i++) begin
         @(negedge clk);
         if (!c_ce) zero_ce++;
         check("c_pins", pk(c_fs, c_hs, c_vs, c_br, c_r, c_g, c_b),
               exp_px(px, py, 1'b1));
         nx = (px == 13) ? 0 : px + 1;
         ny = (px == 13) ? ((py == 6) ? 0 : py + 1) : py;
         check("c_fetch", int'({c_fx, c_fy}), (nx << 10) | ny);
         px = nx;
         py = ny;
      end
      check("c_ce_const", zero_ce, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: run did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int found, seen;
      reset = 1'b0;
      s_en = 1'b1;
      #12;
      check("rst_s_pins", pk(s_fs, s_hs, s_vs, s_br, s_r, s_g, s_b),
            exp_px(-1, 0, 1'b0));
      check("rst_s_fetch", int'({s_fx, s_fy}), 0);
      check("rst_s_ce", int'(s_ce), 0);
      check("rst_c_ce", int'(c_ce), 0);
      check("rst_d_out", int'({d_hs, d_vs, d_br, d_fs}), 4'b1100);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rel_s_ce", int'(s_ce), 0);
      check("rel_c_ce", int'(c_ce), 1);
      fork
         run_s();
         run_d();
         run_v();
         run_c();
      join

      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clk);
         if (s_ce && s_fx == 5 && s_fy == 2) found = 1;
      end
      check("s_find_5_2", found, 1);
      s_en = 1'b0;
      tick(0);
      check("s_park_fetch", int'({s_fx, s_fy}), 0);
      tick(0);
      tick(0);
      check("s_drain", pk(1'b0, s_hs, s_vs, s_br, s_r, s_g, s_b),
            exp_px(-1, 0, 1'b0));
      repeat (3) tick(0);
      check("s_parked", pk(s_fs, s_hs, s_vs, s_br, s_r, s_g, s_b),
            exp_px(-1, 0, 1'b0));
      s_en = 1'b1;
      found = 0;
      seen = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         if (s_fs) seen = 1;
         if (s_br) found = 1;
      end
      check("s_resume_visible", found, 1);
      check("s_resume_fs", seen, 1);
      check("s_resume_px", int'({s_r, s_g}), 0);

      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         @(negedge clk);
         if (s_ce && s_fx == 4 && s_fy == 1) found = 1;
      end
      check("s_find_4_1", found, 1);
      check("s_pre_rst_bright", int'(s_br), 1);
      #1 reset = 1'b0;
      #1;
      check("arst_s_pins", pk(s_fs, s_hs, s_vs, s_br, s_r, s_g, s_b),
            exp_px(-1, 0, 1'b0));
      check("arst_s_fetch", int'({s_fx, s_fy}), 0);
      check("arst_s_ce", int'(s_ce), 0);
      check("arst_c_ce", int'(c_ce), 0);
      check("arst_d_out", int'({d_hs, d_vs, d_br, d_fs}), 4'b1100);
      #1 reset = 1'b1;
      #1;
      check("rel2_s_ce0", int'(s_ce), 0);
      @(negedge clk);
      check("rel2_s_ce1", int'(s_ce), 1);
      check("rel2_s_fetch", int'({s_fx, s_fy}), 0);
      @(negedge clk);
      check("rel2_s_ce2", int'(s_ce), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
